// File: rtl/video_rect_overlay_multi.sv
// Multi-box rectangle overlay on the RGB888 video path.
// Up to NUM_BOX margin-expanded, LINE_W-thick borders, each in its own colour. Box
// coordinates are shadow-latched one entry per clock during vertical blanking, so a
// box never moves mid-frame. Fixed two-clock latency for pixel data and syncs.
module video_rect_overlay_multi #(
    parameter int unsigned NUM_BOX   = 4,
    parameter int unsigned IMG_HDISP = 1280,
    parameter int unsigned IMG_VDISP = 720,
    parameter int unsigned H_MARGIN  = 50,
    parameter int unsigned V_MARGIN  = 20,
    parameter int unsigned LINE_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   overlay_en,
    input  logic                   per_frame_vsync,
    input  logic                   per_frame_href,
    input  logic                   per_frame_clken,
    input  logic [7:0]             per_img_red,
    input  logic [7:0]             per_img_green,
    input  logic [7:0]             per_img_blue,
    input  logic [NUM_BOX*43-1:0]  target_pos,
    input  logic [NUM_BOX*24-1:0]  box_color,
    output logic                   post_frame_vsync,
    output logic                   post_frame_href,
    output logic                   post_frame_clken,
    output logic [7:0]             post_img_red,
    output logic [7:0]             post_img_green,
    output logic [7:0]             post_img_blue,
    output logic [NUM_BOX-1:0]     box_active
);

    localparam int unsigned KW    = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1;
    localparam logic [10:0] XLast = 11'(IMG_HDISP - 1);
    localparam logic [9:0]  YLast = 10'(IMG_VDISP - 1);
    localparam logic [11:0] HMar  = 12'(H_MARGIN);
    localparam logic [11:0] VMar  = 12'(V_MARGIN);
    localparam logic [11:0] HDisp = 12'(IMG_HDISP);
    localparam logic [11:0] VDisp = 12'(IMG_VDISP);
    localparam logic [11:0] LineW = 12'(LINE_W);
    localparam logic [KW-1:0] KLast = KW'(NUM_BOX - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

    // Pixel coordinate counters
    logic [10:0] x_q;
    logic [9:0]  y_q;

    // Frame FSM and loader
    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            rise_seen_q, rise_seen_d;
    logic            vsync_q;
    logic            vs_fall, vs_rise;
    logic            load_en;

    // Loader datapath
    logic [42:0]     ld_pos;
    logic [23:0]     ld_color;
    logic [11:0]     ld_xmin, ld_xmax, ld_ymin, ld_ymax;
    logic [11:0]     ld_left, ld_right, ld_up, ld_down;
    logic            ld_valid;

    // Shadow box set used for drawing
    logic [11:0]     left_q  [NUM_BOX];
    logic [11:0]     right_q [NUM_BOX];
    logic [11:0]     up_q    [NUM_BOX];
    logic [11:0]     down_q  [NUM_BOX];
    logic [23:0]     color_q [NUM_BOX];
    logic [NUM_BOX-1:0] valid_q;

    // Hit test and pipeline
    logic [11:0]        px, py;
    logic [NUM_BOX-1:0] hit;
    logic [NUM_BOX-1:0] hit_d1;
    logic [23:0]        rgb_d1;
    logic               vsync_d1, href_d1, clken_d1;
    logic [23:0]        sel_color;

    assign vs_fall = vsync_q & ~per_frame_vsync;
    assign vs_rise = ~vsync_q & per_frame_vsync;

    // x counts accepted pixels per line, y counts lines and saturates on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (!per_frame_vsync) begin
            x_q <= '0;
            y_q <= '0;
        end else if (per_frame_clken) begin
            if (x_q == XLast) begin
                x_q <= '0;
                if (y_q != YLast) begin
                    y_q <= y_q + 10'd1;
                end
            end else begin
                x_q <= x_q + 11'd1;
            end
        end
    end

    // FSM state, load index and vsync history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            rise_seen_q <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rise_seen_q <= rise_seen_d;
            vsync_q     <= per_frame_vsync;
        end
    end

    // Next-state: load all entries after vsync falls; a vsync rise seen during the load
    // skips the wait state so the next falling edge is not missed
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rise_seen_d = rise_seen_q;
        load_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vs_fall) begin
                    state_d     = StLoad;
                    k_d         = '0;
                    rise_seen_d = 1'b0;
                end
            end
            StLoad: begin
                load_en = 1'b1;
                if (vs_rise) begin
                    rise_seen_d = 1'b1;
                end
                if (k_q == KLast) begin
                    k_d     = '0;
                    state_d = (rise_seen_q || vs_rise) ? StIdle : StWait;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StWait: begin
                if (vs_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Margin expansion with clamping to the active image for the entry being loaded
    always_comb begin
        ld_pos   = target_pos[int'(k_q)*43 +: 43];
        ld_color = box_color[int'(k_q)*24 +: 24];
        ld_xmin  = {1'b0, ld_pos[10:0]};
        ld_ymin  = {2'b0, ld_pos[20:11]};
        ld_xmax  = {1'b0, ld_pos[31:21]};
        ld_ymax  = {2'b0, ld_pos[41:32]};
        ld_up    = (ld_ymin > VMar) ? ld_ymin - VMar : 12'd0;
        ld_left  = (ld_xmin > HMar) ? ld_xmin - HMar : 12'd0;
        ld_down  = (ld_ymax + VMar < VDisp) ? ld_ymax + VMar : VDisp - 12'd1;
        ld_right = (ld_xmax + HMar < HDisp) ? ld_xmax + HMar : HDisp - 12'd1;
        ld_valid = ld_pos[42] & (ld_xmin <= ld_xmax) & (ld_ymin <= ld_ymax);
    end

    // Shadow box registers, written one entry per clock while loading
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_BOX; k++) begin
                left_q[k]  <= '0;
                right_q[k] <= '0;
                up_q[k]    <= '0;
                down_q[k]  <= '0;
                color_q[k] <= '0;
            end
        end else if (load_en) begin
            left_q[k_q]  <= ld_left;
            right_q[k_q] <= ld_right;
            up_q[k_q]    <= ld_up;
            down_q[k_q]  <= ld_down;
            color_q[k_q] <= ld_color;
            valid_q[k_q] <= ld_valid;
        end
    end

    assign px = {1'b0, x_q};
    assign py = {2'b0, y_q};

    // Border hit per box: inside the outer rectangle but not inside the inner one.
    // Inner bounds are written as x+LINE_W<=right to avoid underflow on narrow boxes.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_BOX; k++) begin
            hit[k] = valid_q[k]
                & (left_q[k] <= px) & (px <= right_q[k])
                & (up_q[k] <= py) & (py <= down_q[k])
                & ~((left_q[k] + LineW <= px) & (px + LineW <= right_q[k])
                    & (up_q[k] + LineW <= py) & (py + LineW <= down_q[k]));
        end
    end

    // Stage 1: register input pixel, syncs and hit vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_d1   <= '0;
            vsync_d1 <= 1'b0;
            href_d1  <= 1'b0;
            clken_d1 <= 1'b0;
            hit_d1   <= '0;
        end else begin
            rgb_d1   <= {per_img_red, per_img_green, per_img_blue};
            vsync_d1 <= per_frame_vsync;
            href_d1  <= per_frame_href;
            clken_d1 <= per_frame_clken;
            hit_d1   <= hit;
        end
    end

    // Lowest-index hit box wins where boxes overlap
    always_comb begin
        sel_color = '0;
        for (int k = NUM_BOX - 1; k >= 0; k--) begin
            if (hit_d1[k]) begin
                sel_color = color_q[k];
            end
        end
    end

    // Stage 2: output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_red     <= '0;
            post_img_green   <= '0;
            post_img_blue    <= '0;
        end else begin
            post_frame_vsync <= vsync_d1;
            post_frame_href  <= href_d1;
            post_frame_clken <= clken_d1;
            if (overlay_en && clken_d1 && (|hit_d1)) begin
                {post_img_red, post_img_green, post_img_blue} <= sel_color;
            end else begin
                {post_img_red, post_img_green, post_img_blue} <= rgb_d1;
            end
        end
    end

    assign box_active = valid_q;

endmodule

// File: tb/tb_video_rect_overlay_multi.sv
// Directed bench for video_rect_overlay_multi on a reduced 64x40 image.
module tb_video_rect_overlay_multi;

    localparam int NB = 4;
    localparam int HD = 64;
    localparam int VD = 40;
    localparam int HM = 5;
    localparam int VM = 3;
    localparam int LW = 2;

    localparam logic [23:0] Red   = 24'hFF0000;
    localparam logic [23:0] Green = 24'h00FF00;
    localparam logic [23:0] Blue  = 24'h0000FF;
    localparam logic [23:0] Mag   = 24'hFF00FF;
    localparam logic [23:0] Teal  = 24'h123456;
    localparam logic [23:0] White = 24'hFFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overlay_en = 1'b1;
    logic vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic [NB*43-1:0] target_pos = '0;
    logic [NB*24-1:0] box_color = '0;
    logic post_vs, post_hr, post_ce;
    logic [7:0] post_r, post_g, post_b;
    logic [NB-1:0] box_active;

    int tests = 0;
    int fails = 0;
    int sync_err = 0;
    int pass_err = 0;
    int pix_cnt = 0;
    int ox = 0, oy = 0;
    bit pass_mode = 1'b0;
    logic [26:0] h1 = '0, h2 = '0;
    logic [23:0] out_img [0:VD-1][0:HD-1];

    video_rect_overlay_multi #(
        .NUM_BOX(NB), .IMG_HDISP(HD), .IMG_VDISP(VD),
        .H_MARGIN(HM), .V_MARGIN(VM), .LINE_W(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .overlay_en(overlay_en),
        .per_frame_vsync(vsync),
        .per_frame_href(href),
        .per_frame_clken(clken),
        .per_img_red(r_in),
        .per_img_green(g_in),
        .per_img_blue(b_in),
        .target_pos(target_pos),
        .box_color(box_color),
        .post_frame_vsync(post_vs),
        .post_frame_href(post_hr),
        .post_frame_clken(post_ce),
        .post_img_red(post_r),
        .post_img_green(post_g),
        .post_img_blue(post_b),
        .box_active(box_active)
    );

    always #5 clk = ~clk;

    // Two-clock reference delay line of the inputs (cleared by reset like the outputs)
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 <= '0;
            h2 <= '0;
        end else begin
            h1 <= {vsync, href, clken, r_in, g_in, b_in};
            h2 <= h1;
        end
    end

    // Output monitor: latency, pass-through and frame capture
    always @(negedge clk) begin
        if ({post_vs, post_hr, post_ce} !== h2[26:24]) sync_err <= sync_err + 1;
        if (pass_mode && post_ce && ({post_r, post_g, post_b} !== h2[23:0]))
            pass_err <= pass_err + 1;
        if (post_ce) pix_cnt <= pix_cnt + 1;
        if (!post_vs) begin
            ox <= 0;
            oy <= 0;
        end else if (post_ce) begin
            if (oy < VD && ox < HD) out_img[oy][ox] <= {post_r, post_g, post_b};
            if (ox == HD - 1) begin
                ox <= 0;
                oy <= oy + 1;
            end else begin
                ox <= ox + 1;
            end
        end
    end

    function automatic logic [23:0] inp(input int x, input int y);
        return {8'(x), 8'(y), 8'hA5};
    endfunction

    function automatic logic [42:0] mk_box(input bit f, input int xmin, input int ymin,
                                           input int xmax, input int ymax);
        return {f, 10'(ymax), 11'(xmax), 10'(ymin), 11'(xmin)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input int x, input int y, input logic [23:0] exp);
        chk($sformatf("%s(%0d,%0d)", tag, x, y), 64'(out_img[y][x]), 64'(exp));
    endtask

    task automatic set_box(input int k, input logic [42:0] p, input logic [23:0] c);
        target_pos[k*43 +: 43] = p;
        box_color[k*24 +: 24] = c;
    endtask

    task automatic cfg_moved();
        set_box(0, mk_box(1, 5, 28, 10, 32), Mag);
        set_box(1, mk_box(0, 30, 4, 50, 15), Blue);
        set_box(2, mk_box(0, 50, 30, 60, 35), White);
        set_box(3, mk_box(0, 10, 30, 5, 35), White);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        repeat (8) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_outputs", 64'({post_vs, post_hr, post_ce, post_r, post_g, post_b}), 64'd0);
        chk("rst_box_active", 64'(box_active), 64'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    // One full frame; optional 3-clock clken gap before x=10, target change and reset at a line
    task automatic drive_frame(input bit gaps, input int chg_line, input int rst_line);
        vsync = 1'b0; href = 1'b0; clken = 1'b0;
        {r_in, g_in, b_in} = '0;
        repeat (2) step();
        vsync = 1'b1;
        repeat (4) step();
        for (int y = 0; y < VD; y++) begin
            if (y == chg_line) cfg_moved();
            if (y == rst_line) do_reset();
            href = 1'b1;
            for (int x = 0; x < HD; x++) begin
                if (gaps && x == 10) begin
                    clken = 1'b0;
                    {r_in, g_in, b_in} = 24'h0F0F0F;
                    repeat (3) step();
                end
                clken = 1'b1;
                {r_in, g_in, b_in} = inp(x, y);
                step();
            end
            clken = 1'b0; href = 1'b0;
            {r_in, g_in, b_in} = '0;
            repeat (4) step();
        end
        repeat (4) step();
        vsync = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        int p0;
        int c0;

        repeat (3) step();
        chk("reset_state",
            64'({post_vs, post_hr, post_ce, post_r, post_g, post_b, box_active}), 64'd0);
        rst = 1'b0;
        step();

        // Single red box: expanded to x 15..35, y 7..23, inner x 17..33, y 9..21
        set_box(0, mk_box(1, 20, 10, 30, 20), Red);
        vsync_pulse();
        chk("f1_box_active", 64'(box_active), 64'h1);
        drive_frame(0, -1, -1);
        chk_px("f1", 15, 7, Red);
        chk_px("f1", 35, 23, Red);
        chk_px("f1", 25, 8, Red);
        chk_px("f1", 25, 22, Red);
        chk_px("f1", 25, 9, inp(25, 9));
        chk_px("f1", 16, 15, Red);
        chk_px("f1", 17, 15, inp(17, 15));
        chk_px("f1", 34, 15, Red);
        chk_px("f1", 33, 15, inp(33, 15));
        chk_px("f1", 14, 7, inp(14, 7));
        chk_px("f1", 36, 23, inp(36, 23));
        chk_px("f1", 25, 6, inp(25, 6));
        chk_px("f1", 25, 24, inp(25, 24));

        // Clamping: expands past every image edge -> 0..63 x 0..39
        set_box(0, mk_box(1, 3, 2, 60, 37), Teal);
        vsync_pulse();
        drive_frame(0, -1, -1);
        chk_px("f2", 0, 0, Teal);
        chk_px("f2", 63, 39, Teal);
        chk_px("f2", 1, 20, Teal);
        chk_px("f2", 62, 20, Teal);
        chk_px("f2", 30, 38, Teal);
        chk_px("f2", 2, 2, inp(2, 2));
        chk_px("f2", 61, 37, inp(61, 37));

        // Overlap: box0 green 15..45 x 7..23, box1 blue 25..55 x 1..18; box2 flag 0; box3 xmin>xmax
        set_box(0, mk_box(1, 20, 10, 40, 20), Green);
        set_box(1, mk_box(1, 30, 4, 50, 15), Blue);
        set_box(2, mk_box(0, 50, 30, 60, 35), White);
        set_box(3, mk_box(1, 10, 30, 5, 35), White);
        vsync_pulse();
        chk("f3_box_active", 64'(box_active), 64'h3);
        drive_frame(0, -1, -1);
        chk_px("f3", 25, 7, Green);
        chk_px("f3", 26, 8, Green);
        chk_px("f3", 50, 1, Blue);
        chk_px("f3", 54, 10, Blue);
        chk_px("f3", 45, 20, Green);
        chk_px("f3", 30, 15, inp(30, 15));
        chk_px("f3", 45, 27, inp(45, 27));
        chk_px("f3", 5, 27, inp(5, 27));

        // Overlay disabled: full pass-through
        overlay_en = 1'b0;
        pass_mode = 1'b1;
        p0 = pass_err;
        drive_frame(0, -1, -1);
        chk("f4_pass_errors", 64'(pass_err - p0), 64'd0);
        chk_px("f4", 25, 7, inp(25, 7));
        overlay_en = 1'b1;
        pass_mode = 1'b0;

        // Targets change at line 20: this frame keeps the old boxes
        drive_frame(0, 20, -1);
        chk_px("f5", 15, 23, Green);
        chk_px("f5", 30, 22, Green);
        chk_px("f5", 0, 25, inp(0, 25));
        chk("f5_box_active_next", 64'(box_active), 64'h1);

        // New box: 0..15 x 25..35, inner 2..13 x 27..33
        drive_frame(0, -1, -1);
        chk_px("f6", 0, 25, Mag);
        chk_px("f6", 15, 35, Mag);
        chk_px("f6", 1, 27, Mag);
        chk_px("f6", 2, 27, inp(2, 27));
        chk_px("f6", 15, 23, inp(15, 23));
        chk_px("f6", 30, 22, inp(30, 22));

        // clken gaps inside every line
        c0 = pix_cnt;
        drive_frame(1, -1, -1);
        chk("f7_pixel_count", 64'(pix_cnt - c0), 64'(HD * VD));
        chk_px("f7", 15, 30, Mag);
        chk_px("f7", 14, 30, Mag);
        chk_px("f7", 13, 30, inp(13, 30));
        chk_px("f7", 16, 30, inp(16, 30));
        chk_px("f7", 10, 30, inp(10, 30));
        chk_px("f7", 10, 25, Mag);

        // Reset mid-frame: rest of the frame passes through
        pass_mode = 1'b1;
        p0 = pass_err;
        drive_frame(0, -1, 5);
        chk("f8_pass_errors", 64'(pass_err - p0), 64'd0);
        pass_mode = 1'b0;
        chk("f8_box_active_next", 64'(box_active), 64'h1);

        drive_frame(0, -1, -1);
        chk_px("f9", 0, 25, Mag);
        chk_px("f9", 8, 27, inp(8, 27));

        chk("sync_latency_errors", 64'(sync_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
